// File: rtl/interfaz_lectura_picoblaze_pkg.sv
// interfaz_lectura_picoblaze_pkg: port ids, key codes and interrupt FSM states
// shared by the PicoBlaze read and config write decoders.
package interfaz_lectura_picoblaze_pkg;
    localparam logic [7:0] ID_SS     = 8'h00;
    localparam logic [7:0] ID_MM     = 8'h01;
    localparam logic [7:0] ID_HH     = 8'h02;
    localparam logic [7:0] ID_DAY    = 8'h03;
    localparam logic [7:0] ID_MES    = 8'h04;
    localparam logic [7:0] ID_YEAR   = 8'h05;
    localparam logic [7:0] ID_SS_T   = 8'h06;
    localparam logic [7:0] ID_MM_T   = 8'h07;
    localparam logic [7:0] ID_HH_T   = 8'h08;
    localparam logic [7:0] ID_STATUS = 8'h0F;
    localparam logic [7:0] ID_KEY    = 8'h10;
    localparam logic [7:0] ID_CFG    = 8'h11;

    localparam logic [7:0] KEY_RIGHT  = 8'h04;
    localparam logic [7:0] KEY_UP     = 8'h05;
    localparam logic [7:0] KEY_DOWN   = 8'h06;
    localparam logic [7:0] KEY_LEFT   = 8'h07;
    localparam logic [7:0] KEY_CONFIG = 8'h08;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} irq_state_t;
endpackage

// File: rtl/interfaz_lectura_picoblaze_fifo_teclas.sv
// fifo_teclas: single-clock key FIFO; a push on a full FIFO is accepted only
// when a pop frees the head slot in the same cycle.
module fifo_teclas #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic                            pop,
    input  logic [7:0]                      din,
    output logic [7:0]                      dout,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH):0]     count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr, rd;

    assign full  = count == CW'(FIFO_DEPTH);
    assign empty = count == '0;
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= din;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr) - CW'(rd);
        end
    end
endmodule

// File: rtl/interfaz_lectura_picoblaze.sv
// interfaz_lectura_picoblaze: PicoBlaze in_port read mux, key FIFO with
// priority push and sticky overflow, and interrupt request/ack handshake.
module interfaz_lectura_picoblaze
    import interfaz_lectura_picoblaze_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] PORT_STATUS = ID_STATUS,
    parameter logic [7:0] PORT_KEY    = ID_KEY,
    parameter logic [7:0] PORT_CFG    = ID_CFG
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_config,
    input  logic [1:0] cfg_mode,
    input  logic [1:0] cursor,
    input  logic [7:0] data_SS,
    input  logic [7:0] data_MM,
    input  logic [7:0] data_HH,
    input  logic [7:0] data_DAY,
    input  logic [7:0] data_MES,
    input  logic [7:0] data_YEAR,
    input  logic [7:0] data_SS_T,
    input  logic [7:0] data_MM_T,
    input  logic [7:0] data_HH_T
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    irq_state_t    state, state_nxt;
    logic [4:0]    btn;
    logic [7:0]    key_code, head, cnt8, sel, status;
    logic [2:0]    cnt3;
    logic [CW-1:0] count;
    logic          push, pop, full, empty, overflow, ovf_set, ovf_clr;

    assign btn      = {btn_config, btn_left, btn_right, btn_up, btn_down};
    assign key_code = btn_config ? KEY_CONFIG : btn_left ? KEY_LEFT :
                      btn_right  ? KEY_RIGHT  : btn_up   ? KEY_UP   : KEY_DOWN;
    assign push     = |btn;
    assign pop      = read_strobe && port_id == PORT_KEY && !empty;
    assign ovf_clr  = read_strobe && port_id == PORT_STATUS;
    assign ovf_set  = $countones(btn) > 1 || (push && full && !pop);
    assign interrupt = state == REQ;

    fifo_teclas #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (key_code),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Status count field is only 3 bits wide; clamp deeper FIFOs at 7.
    assign cnt8   = 8'(count);
    assign cnt3   = cnt8 > 8'd7 ? 3'd7 : cnt8[2:0];
    assign status = {empty, full, overflow, state == REQ, 1'b0, cnt3};

    always_comb begin
        sel = 8'h00;
        case (port_id)
            ID_SS:       sel = data_SS;
            ID_MM:       sel = data_MM;
            ID_HH:       sel = data_HH;
            ID_DAY:      sel = data_DAY;
            ID_MES:      sel = data_MES;
            ID_YEAR:     sel = data_YEAR;
            ID_SS_T:     sel = data_SS_T;
            ID_MM_T:     sel = data_MM_T;
            ID_HH_T:     sel = data_HH_T;
            PORT_STATUS: sel = status;
            PORT_KEY:    sel = empty ? 8'h00 : head;
            PORT_CFG:    sel = {3'b000, cfg_mode, 1'b0, cursor};
            default:     sel = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = empty ? IDLE : REQ;
            REQ:     state_nxt = interrupt_ack ? DRAIN : REQ;
            DRAIN:   state_nxt = empty ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_port  <= 8'h00;
            overflow <= 1'b0;
            state    <= IDLE;
        end else begin
            in_port  <= sel;
            overflow <= ovf_set || (overflow && !ovf_clr);
            state    <= state_nxt;
        end
    end
endmodule

// File: tb/tb_interfaz_lectura_picoblaze.sv
// tb_interfaz_lectura_picoblaze: directed scenarios plus randomized traffic,
// checked against a queue-based behavioural model of the read interface.
module tb_interfaz_lectura_picoblaze;
    import interfaz_lectura_picoblaze_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] port_id = 8'h00;
    logic       read_strobe = 1'b0, interrupt_ack = 1'b0;
    logic       btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_config = 1'b0;
    logic [1:0] cfg_mode = 2'b00, cursor = 2'b00;
    logic [7:0] data_SS = 8'h00, data_MM = 8'h00, data_HH = 8'h00, data_DAY = 8'h00, data_MES = 8'h00;
    logic [7:0] data_YEAR = 8'h00, data_SS_T = 8'h00, data_MM_T = 8'h00, data_HH_T = 8'h00;
    logic [7:0] in_port;
    logic       interrupt;

    int vectors = 0;
    int errors = 0;

    byte unsigned mq[$];
    bit           m_ovf = 1'b0;
    int           m_phase = 0;
    logic [7:0]   m_in = 8'h00;

    always #5 clk = ~clk;

    interfaz_lectura_picoblaze #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .read_strobe(read_strobe),
        .in_port(in_port), .interrupt(interrupt), .interrupt_ack(interrupt_ack),
        .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_config(btn_config), .cfg_mode(cfg_mode), .cursor(cursor),
        .data_SS(data_SS), .data_MM(data_MM), .data_HH(data_HH), .data_DAY(data_DAY),
        .data_MES(data_MES), .data_YEAR(data_YEAR), .data_SS_T(data_SS_T),
        .data_MM_T(data_MM_T), .data_HH_T(data_HH_T)
    );

    function automatic logic [7:0] m_read(input logic [7:0] p);
        logic [2:0] c;
        c = 3'(mq.size());
        case (p)
            8'h00: return data_SS;
            8'h01: return data_MM;
            8'h02: return data_HH;
            8'h03: return data_DAY;
            8'h04: return data_MES;
            8'h05: return data_YEAR;
            8'h06: return data_SS_T;
            8'h07: return data_MM_T;
            8'h08: return data_HH_T;
            8'h0F: return {mq.size() == 0, mq.size() == DEPTH, m_ovf, m_phase == 1, 1'b0, c};
            8'h10: return mq.size() > 0 ? mq[0] : 8'h00;
            8'h11: return {3'b000, cfg_mode, 1'b0, cursor};
            default: return 8'h00;
        endcase
    endfunction

    // Advance one clock: model consumes the pre-edge inputs, pulses are cleared after.
    task automatic step();
        logic [7:0]  nin;
        int          np, pre;
        bit          pop, clr, dropped;
        byte unsigned code;
        nin  = m_read(port_id);
        pre  = mq.size();
        np   = $countones({btn_config, btn_left, btn_right, btn_up, btn_down});
        code = btn_config ? 8'h08 : btn_left ? 8'h07 : btn_right ? 8'h04 : btn_up ? 8'h05 : 8'h06;
        pop  = read_strobe && port_id == 8'h10 && pre > 0;
        clr  = read_strobe && port_id == 8'h0F;
        @(posedge clk);
        #1;
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
            m_phase = 0;
            m_in = 8'h00;
        end else begin
            m_in = nin;
            if (m_phase == 0 && pre != 0) m_phase = 1;
            else if (m_phase == 1 && interrupt_ack) m_phase = 2;
            else if (m_phase == 2 && pre == 0) m_phase = 0;
            if (pop) void'(mq.pop_front());
            dropped = 1'b0;
            if (np > 0) begin
                if (pre < DEPTH || pop) mq.push_back(code);
                else dropped = 1'b1;
            end
            m_ovf = (np > 1) || dropped || (m_ovf && !clr);
        end
        {btn_right, btn_up, btn_down, btn_left, btn_config} = 5'b0;
        read_strobe = 1'b0;
        interrupt_ack = 1'b0;
    endtask

    task automatic drain();
        step();
        if (m_phase == 1) begin
            interrupt_ack = 1'b1;
            step();
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            port_id = 8'h10;
            read_strobe = 1'b1;
            step();
        end
        port_id = 8'h0F;
        read_strobe = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vectors++;
        if (in_port !== 8'h00 || interrupt !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: in_port=%h interrupt=%b, required 00/0", in_port, interrupt);
        end
        reset = 1'b0;
        port_id = 8'h0F;
        step();
        vectors++;
        if (in_port !== 8'h80) begin
            errors++;
            $display("FAIL reset_status: got %h required 80", in_port);
        end
        data_HH = 8'h13;
        port_id = 8'h02;
        step();
        vectors++;
        if (in_port !== 8'h13 || in_port !== m_in) begin
            errors++;
            $display("FAIL read_hh: got %h required 13", in_port);
        end
        port_id = 8'h3A;
        step();
        vectors++;
        if (in_port !== 8'h00) begin
            errors++;
            $display("FAIL unmapped_port: got %h required 00", in_port);
        end
    endtask

    task automatic test_single_key();
        btn_up = 1'b1;
        step();
        step();
        vectors++;
        if (interrupt !== 1'b1) begin
            errors++;
            $display("FAIL irq_raise: got %b required 1", interrupt);
        end
        interrupt_ack = 1'b1;
        step();
        vectors++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL irq_ack: got %b required 0", interrupt);
        end
        port_id = 8'h10;
        read_strobe = 1'b1;
        step();
        vectors++;
        if (in_port !== 8'h05) begin
            errors++;
            $display("FAIL key_up: got %h required 05", in_port);
        end
        port_id = 8'h0F;
        step();
        step();
        vectors++;
        if (in_port !== 8'h80 || in_port !== m_in) begin
            errors++;
            $display("FAIL status_after_drain: got %h required 80", in_port);
        end
    endtask

    task automatic test_overflow();
        port_id = 8'h0F;
        for (int i = 0; i < 5; i++) begin
            btn_left = 1'b1;
            step();
        end
        step();
        vectors++;
        if (in_port !== 8'h74 || in_port !== m_in) begin
            errors++;
            $display("FAIL status_full_ovf: got %h required 74 (model %h)", in_port, m_in);
        end
        read_strobe = 1'b1;
        step();
        step();
        vectors++;
        if (in_port !== 8'h54 || in_port !== m_in) begin
            errors++;
            $display("FAIL status_ovf_cleared: got %h required 54 (model %h)", in_port, m_in);
        end
        drain();
    endtask

    task automatic test_simultaneous();
        btn_config = 1'b1;
        btn_down = 1'b1;
        step();
        port_id = 8'h10;
        step();
        vectors++;
        if (in_port !== 8'h08) begin
            errors++;
            $display("FAIL priority_head: got %h required 08", in_port);
        end
        port_id = 8'h0F;
        step();
        vectors++;
        if (in_port[5] !== 1'b1 || in_port[2:0] !== 3'd1 || in_port !== m_in) begin
            errors++;
            $display("FAIL priority_status: got %h required %h", in_port, m_in);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        btn_up = 1'b1;
        step();
        btn_down = 1'b1;
        step();
        btn_left = 1'b1;
        step();
        btn_config = 1'b1;
        step();
        port_id = 8'h10;
        read_strobe = 1'b1;
        btn_right = 1'b1;
        step();
        vectors++;
        if (in_port !== 8'h05) begin
            errors++;
            $display("FAIL full_pop_push_head: got %h required 05", in_port);
        end
        port_id = 8'h0F;
        step();
        vectors++;
        if (in_port[6] !== 1'b1 || in_port[5] !== 1'b0 || in_port[2:0] !== 3'd4 || in_port !== m_in) begin
            errors++;
            $display("FAIL full_pop_push_status: got %h required %h", in_port, m_in);
        end
        for (int i = 0; i < DEPTH; i++) begin
            port_id = 8'h10;
            read_strobe = 1'b1;
            step();
            vectors++;
            if (in_port !== m_in) begin
                errors++;
                $display("FAIL drain_pop_%0d: got %h required %h", i, in_port, m_in);
            end
        end
        vectors++;
        if (in_port !== 8'h04) begin
            errors++;
            $display("FAIL tail_right: got %h required 04", in_port);
        end
        drain();
    endtask

    task automatic test_cfg_and_reset();
        bit seen;
        cfg_mode = 2'b10;
        cursor = 2'b01;
        port_id = 8'h11;
        step();
        vectors++;
        if (in_port !== 8'h11) begin
            errors++;
            $display("FAIL cfg_readback: got %h required 11", in_port);
        end
        btn_right = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            step();
            seen = interrupt;
        end
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL irq_timeout: interrupt=%b required 1 within 4 cycles", interrupt);
        end
        reset = 1'b1;
        interrupt_ack = 1'b1;
        step();
        vectors++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b required 0", interrupt);
        end
        reset = 1'b0;
        port_id = 8'h0F;
        step();
        vectors++;
        if (in_port !== 8'h80) begin
            errors++;
            $display("FAIL reset_status_after: got %h required 80", in_port);
        end
    endtask

    task automatic test_random();
        logic [7:0] ports [14] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                   8'h07, 8'h08, 8'h0F, 8'h10, 8'h10, 8'h11, 8'h20};
        for (int i = 0; i < 600; i++) begin
            {data_SS, data_MM, data_HH, data_DAY} = $urandom;
            {data_MES, data_YEAR, data_SS_T, data_MM_T} = $urandom;
            data_HH_T = 8'($urandom);
            {cfg_mode, cursor} = 4'($urandom);
            port_id = ports[$urandom_range(0, 13)];
            read_strobe = $urandom_range(0, 2) == 0;
            interrupt_ack = $urandom_range(0, 3) == 0;
            btn_right = $urandom_range(0, 7) == 0;
            btn_up = $urandom_range(0, 7) == 0;
            btn_down = $urandom_range(0, 7) == 0;
            btn_left = $urandom_range(0, 7) == 0;
            btn_config = $urandom_range(0, 7) == 0;
            reset = $urandom_range(0, 199) == 0;
            step();
            vectors++;
            if (in_port !== m_in || interrupt !== (m_phase == 1)) begin
                errors++;
                $display("FAIL random_%0d: in_port=%h irq=%b required %h/%b", i, in_port, interrupt, m_in, m_phase == 1);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_overflow();
        test_simultaneous();
        test_back_to_back();
        test_cfg_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
